// File: rtl/multi_pulse_gen.sv
// -----------------------------------------------------------------------------
// multi_pulse_gen
//   N_CH independent one-shot pulse generators sharing one clock and reset.
//   Each channel resynchronises its trigger input, waits in IDLE until it is
//   armed (en) and the input is at its active level, then drives pulse high
//   for exactly PULSE_LEN cycles. A held input produces a single pulse: the
//   channel parks in WAIT_REL until the input goes inactive again.
//
// Ports
//   clk    rising-edge clock for all logic
//   rst_n  asynchronous active-low reset
//   in     [N_CH] trigger inputs, asynchronous to clk
//   en     [N_CH] arm enables, synchronous to clk, only sampled in IDLE
//   pulse  [N_CH] registered one-shot outputs
//   busy   [N_CH] registered, high while the channel is not IDLE
// -----------------------------------------------------------------------------
module multi_pulse_gen #(
  parameter int N_CH        = 4,
  parameter int PULSE_LEN   = 1,
  parameter int SYNC_STAGES = 2,
  parameter int POLARITY    = 1,
  parameter int RETRIG      = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] in,
  input  logic [N_CH-1:0] en,
  output logic [N_CH-1:0] pulse,
  output logic [N_CH-1:0] busy
);

  // Counter holds PULSE_LEN-1 down to 0.
  localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  localparam logic ACT_LVL   = (POLARITY != 0);
  localparam logic INACT_LVL = !ACT_LVL;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PULSE    = 2'd1,
    S_WAIT_REL = 2'd2
  } state_t;

  logic [N_CH-1:0] in_s;
  logic [N_CH-1:0] prev_q;
  logic [N_CH-1:0] act;
  logic [N_CH-1:0] act_prev;
  logic [N_CH-1:0] activation;

  // Input synchroniser
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign in_s = in;
    end else begin : g_sync
      logic [N_CH-1:0] sync_q [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            sync_q[k] <= {N_CH{INACT_LVL}};
          end
        end else begin
          sync_q[0] <= in;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_q[k] <= sync_q[k-1];
          end
        end
      end

      assign in_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Previous-cycle copy of the synchronised input, for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= {N_CH{INACT_LVL}};
    end else begin
      prev_q <= in_s;
    end
  end

  // XOR with the inactive level normalises both polarities to active-high.
  assign act        = in_s   ^ {N_CH{INACT_LVL}};
  assign act_prev   = prev_q ^ {N_CH{INACT_LVL}};
  assign activation = act & ~act_prev;

  // Per-channel FSM and registered outputs
  generate
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
      state_t           state_q;
      state_t           state_d;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             pulse_q;
      logic             busy_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          pulse_q <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
          // Outputs follow the next state so they rise on the same edge
          // the FSM enters PULSE.
          pulse_q <= (state_d == S_PULSE);
          busy_q  <= (state_d != S_IDLE);
        end
      end

      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          S_IDLE: begin
            // Level-triggered from IDLE so an input already active when
            // the channel is armed still yields one pulse.
            if (en[g] && act[g]) begin
              state_d = S_PULSE;
              cnt_d   = CNT_LOAD;
            end
          end
          S_PULSE: begin
            // A reload takes priority over expiry, so a retrigger on the
            // last cycle extends the pulse without a gap.
            if ((RETRIG != 0) && activation[g]) begin
              cnt_d = CNT_LOAD;
            end else if (cnt_q == '0) begin
              cnt_d   = '0;
              state_d = act[g] ? S_WAIT_REL : S_IDLE;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
          S_WAIT_REL: begin
            if (!act[g]) begin
              state_d = S_IDLE;
            end
          end
          default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      assign pulse[g] = pulse_q;
      assign busy[g]  = busy_q;
    end
  endgenerate

endmodule

// File: doc/multi_pulse_gen.md
MULTI_PULSE_GEN -- requirements
Module: multi_pulse_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  N_CH         4   number of independent channels, >=1
  PULSE_LEN    1   output pulse width in clk cycles, 1..65535
  SYNC_STAGES  2   input synchroniser flops per channel, 0..3 (0 = input used directly)
  POLARITY     1   active input level (1 = trigger on high, 0 = trigger on low)
  RETRIG       0   1 = new activation during a pulse restarts its width; 0 = ignored
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk    input   1     single clock, all logic on rising edge
  rst_n  input   1     asynchronous, active-low reset
  in     input   N_CH  per-channel trigger inputs, asynchronous to clk
  en     input   N_CH  per-channel arm enable, synchronous to clk
  pulse  output  N_CH  per-channel one-shot pulse, registered
  busy   output  N_CH  per-channel high whenever the channel is not IDLE, registered
REQ-003 One clock, clk; reset rst_n is asynchronous and active-low.
REQ-004 The width of the internal counter SHALL be derived from PULSE_LEN; no wider than needed.

Function
REQ-005 Each channel SHALL be an independent FSM; channels share only clk and rst_n.
REQ-006 in_s[i] = in[i] after SYNC_STAGES flops; "active" means in_s[i] == POLARITY.
REQ-007 "Activation" = in_s[i] inactive on the previous cycle and active on the current cycle.
REQ-008 States: IDLE, PULSE, WAIT_REL; encoding is free, with no unreachable lock-up.
REQ-009 IDLE: if en[i]=1 and in_s[i] is active -> PULSE, load counter = PULSE_LEN-1, pulse[i] goes to 1 on the same edge.
REQ-010 IDLE with en[i]=0: stay in IDLE regardless of in_s[i]; pulse[i]=0.
REQ-011 PULSE: decrement the counter each cycle; pulse[i] SHALL stay 1 for exactly PULSE_LEN consecutive cycles per trigger (PULSE_LEN=1 gives a single-cycle pulse).
REQ-012 PULSE with RETRIG=1 and an activation: reload counter = PULSE_LEN-1; pulse[i] stays 1 with no gap.
REQ-013 PULSE with RETRIG=0: activations are ignored.
REQ-014 PULSE, counter=0, and no reload: pulse[i] -> 0.
  - If in_s[i] is still active -> WAIT_REL.
  - Otherwise -> IDLE.
REQ-015 WAIT_REL: pulse[i]=0; -> IDLE on the first cycle in_s[i] is inactive. A held input SHALL yield exactly one pulse.
REQ-016 Deasserting en[i] during PULSE or WAIT_REL SHALL NOT truncate a pulse; en is only checked in IDLE.
REQ-017 Simultaneous events: counter=0 coinciding with an activation and RETRIG=1 -> the reload wins, and the pulse continues PULSE_LEN more cycles.
REQ-018 Latency (SYNC_STAGES=S, in stable for >=1 cycle with setup met): pulse[i] rises on the (S+1)th rising clk edge after the in[i] transition.
REQ-019 busy[i] SHALL be 1 in PULSE and WAIT_REL, and 0 in IDLE.

Reset
REQ-020 rst_n=0 SHALL immediately, without clk, force:
  - all channels to IDLE;
  - pulse=0, busy=0, counters=0;
  - synchroniser and previous-value flops to the inactive level (~POLARITY).
REQ-021 Reset mid-pulse SHALL terminate the pulse at once; no pulse is emitted on deassertion unless in_s later becomes active with en=1.
REQ-022 After rst_n rises, a continuously active in[i] SHALL produce one pulse (level seen from IDLE), not zero and not repeated.

Verification
REQ-023 N_CH=4, PULSE_LEN=3, S=2, POLARITY=1, RETRIG=0, en=4'hF; in[0] 0->1 held 10 cycles -> pulse[0] high cycles 3-5 after the edge, busy[0] high through WAIT_REL, no second pulse.
REQ-024 Same configuration; in[1] high 1 cycle -> pulse[1] high exactly 3 cycles; then IDLE, busy[1]=0.
REQ-025 RETRIG=1, PULSE_LEN=4; in[2] pulsed high at t and t+2 (one cycle each, low between) -> pulse[2] high continuously for 6 cycles; RETRIG=0 -> 4 cycles.
REQ-026 en[3]=0 with in[3] high -> no pulse; raise en[3] while in[3] is still high -> one 3-cycle pulse; drop en[3] mid-pulse -> pulse still 3 cycles.
REQ-027 POLARITY=0, PULSE_LEN=1; in=4'hF through reset release -> no pulse; in[0] ->0 -> 1-cycle pulse[0], other channels quiet.
REQ-028 Assert rst_n=0 asynchronously mid-pulse -> pulse and busy are 0 before the next clk edge; release with in low -> all outputs stay 0.
